// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target (slave) port answering one 7-bit address.
//               SCL/SDA are synchronised to clk (two flops plus one edge
//               detect stage), START/STOP are decoded, and a byte engine
//               handles address, write and read phases with ACK/NACK.
//               Optional macro I2C_TARGET_GCALL_EN additionally ACKs the
//               general-call address (7'h00, write only).
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous reset, active low
//               scl_in   - raw SCL pin level
//               sda_in   - raw SDA pin level
//               sda_oe   - 1 pulls SDA low, 0 releases it
//               rx_data  - last byte written by the controller
//               rx_valid - one-cycle strobe, rx_data is new
//               tx_data  - byte returned on a read
//               tx_req   - one-cycle strobe, next read byte is needed
//               busy     - addressed and transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6
    } state_t;

    // [0] first sync flop, [1] second sync flop, [2] edge-detect stage
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;
    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_sync[1] &  scl_sync[2] &  sda_sync[2] & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] &  scl_sync[2] & ~sda_sync[2] &  sda_sync[1];

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] shift, shift_n;        // first seven bits of the incoming byte
    logic [6:0] tx_shift, tx_shift_n;  // read bits still to be driven
    logic       rw, rw_n;
    logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n;
    logic [7:0] rx_data_n;

    // Complete byte as it stands once the current SDA sample is appended
    logic [7:0] byte_in;
    assign byte_in = {shift, sda_s};

    logic addr_hit;
`ifdef I2C_TARGET_GCALL_EN
    assign addr_hit = (byte_in[7:1] == TARGET_ADDR) || (byte_in == 8'h00);
`else
    assign addr_hit = (byte_in[7:1] == TARGET_ADDR);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            tx_shift <= 7'd0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            tx_shift <= tx_shift_n;
            rw       <= rw_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        tx_shift_n = tx_shift;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = byte_in[6:0];
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = 3'd0;
                            rw_n      = sda_s;
                            busy_n    = addr_hit;
                            state_n   = addr_hit ? ADDR_ACK : IDLE;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end

                // bit_cnt 0: first fall drives ACK; the 9th rise sets it to 1;
                // the following fall ends the ACK slot.
                ADDR_ACK, WRITE_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                state_n    = READ;
                                tx_shift_n = tx_data[6:0];
                                sda_oe_n   = ~tx_data[7];
                            end else begin
                                state_n  = WRITE;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end else if (scl_rise) begin
                        bit_cnt_n = 3'd1;
                        if (state == ADDR_ACK && rw) begin
                            tx_req_n = 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_n = byte_in[6:0];
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = byte_in;
                            rx_valid_n = 1'b1;
                            state_n    = WRITE_ACK;
                            bit_cnt_n  = 3'd0;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end

                READ: begin
                    if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            state_n   = READ_ACK;
                            bit_cnt_n = 3'd0;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else if (scl_fall) begin
                        sda_oe_n   = ~tx_shift[6];
                        tx_shift_n = {tx_shift[5:0], 1'b0};
                    end
                end

                READ_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                        end else begin
                            state_n    = READ;
                            bit_cnt_n  = 3'd0;
                            tx_shift_n = tx_data[6:0];
                            sda_oe_n   = ~tx_data[7];
                        end
                    end else if (scl_rise) begin
                        if (sda_s) begin
                            // NACK: stop responding, busy stays until STOP/START
                            state_n   = IDLE;
                            bit_cnt_n = 3'd0;
                        end else begin
                            bit_cnt_n = 3'd1;
                            tx_req_n  = 1'b1;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
